// File: rtl/mash_sdm_gen2.sv
// MASH 1-1-1 sigma-delta modulator with selectable order (1..3) and LFSR LSB dither.
// Three cascaded W-bit accumulators feed a carry noise-cancellation network; output is 4-bit signed.
module mash_sdm_gen2 #(
    parameter int          W         = 10,
    parameter logic [14:0] LFSR_SEED = 15'h0001
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] din,
    input  logic [1:0]   order,
    input  logic         dither_en,
    output logic [3:0]   sdm_out,
    output logic         out_vld,
    output logic         carry1
);

    logic [W-1:0] r_acc1;
    logic [W-1:0] r_acc2;
    logic [W-1:0] r_acc3;
    logic         r_c2d1;
    logic         r_c3d1;
    logic         r_c3d2;
    logic [14:0]  r_lfsr;
    logic [1:0]   r_ordQ;

    logic         w_dith;
    logic [W:0]   w_s1;
    logic [W:0]   w_s2;
    logic [W:0]   w_s3;
    logic         w_c1;
    logic         w_c2;
    logic         w_c3;
    logic         w_lfsrFb;
    logic signed [4:0] w_e1;
    logic signed [4:0] w_e2;
    logic signed [4:0] w_e3;
    logic signed [4:0] w_y;

    assign w_dith   = dither_en & r_lfsr[0];
    assign w_lfsrFb = r_lfsr[14] ^ r_lfsr[13];

    // Whole accumulator chain settles combinationally within one step.
    assign w_s1 = {1'b0, r_acc1} + {1'b0, din} + {{W{1'b0}}, w_dith};
    assign w_s2 = {1'b0, r_acc2} + {1'b0, w_s1[W-1:0]};
    assign w_s3 = {1'b0, r_acc3} + {1'b0, w_s2[W-1:0]};

    assign w_c1 = w_s1[W];
    assign w_c2 = w_s2[W];
    assign w_c3 = w_s3[W];

    // Noise-cancellation terms; 5 bits keeps every intermediate clear of wrap.
    assign w_e1 = $signed({4'b0000, w_c1});
    assign w_e2 = $signed({4'b0000, w_c2}) - $signed({4'b0000, r_c2d1});
    assign w_e3 = $signed({4'b0000, w_c3}) - $signed({3'b000, r_c3d1, 1'b0})
                + $signed({4'b0000, r_c3d2});

    always_comb begin
        w_y = 5'sd0;
        case (r_ordQ)
            2'd1:    w_y = w_e1;
            2'd2:    w_y = w_e1 + w_e2;
            2'd3:    w_y = w_e1 + w_e2 + w_e3;
            default: w_y = 5'sd0;
        endcase
    end

    // Priority: reset, then order change, then idle order, then enabled step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc1  <= '0;
            r_acc2  <= '0;
            r_acc3  <= '0;
            r_c2d1  <= 1'b0;
            r_c3d1  <= 1'b0;
            r_c3d2  <= 1'b0;
            r_lfsr  <= LFSR_SEED;
            r_ordQ  <= order;
            sdm_out <= 4'd0;
            out_vld <= 1'b0;
            carry1  <= 1'b0;
        end else if (order != r_ordQ) begin
            r_ordQ  <= order;
            r_acc1  <= '0;
            r_acc2  <= '0;
            r_acc3  <= '0;
            r_c2d1  <= 1'b0;
            r_c3d1  <= 1'b0;
            r_c3d2  <= 1'b0;
            sdm_out <= 4'd0;
            out_vld <= 1'b0;
        end else if (r_ordQ == 2'd0) begin
            r_acc1  <= '0;
            r_acc2  <= '0;
            r_acc3  <= '0;
            r_c2d1  <= 1'b0;
            r_c3d1  <= 1'b0;
            r_c3d2  <= 1'b0;
            sdm_out <= 4'd0;
            out_vld <= 1'b0;
        end else if (en) begin
            r_acc1 <= w_s1[W-1:0];
            // Stages beyond the selected order stay parked at zero.
            if (r_ordQ >= 2'd2) begin
                r_acc2 <= w_s2[W-1:0];
                r_c2d1 <= w_c2;
            end else begin
                r_acc2 <= '0;
                r_c2d1 <= 1'b0;
            end
            if (r_ordQ == 2'd3) begin
                r_acc3 <= w_s3[W-1:0];
                r_c3d1 <= w_c3;
                r_c3d2 <= r_c3d1;
            end else begin
                r_acc3 <= '0;
                r_c3d1 <= 1'b0;
                r_c3d2 <= 1'b0;
            end
            r_lfsr  <= {r_lfsr[13:0], w_lfsrFb};
            sdm_out <= w_y[3:0];
            carry1  <= w_c1;
            out_vld <= 1'b1;
        end else begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: doc/mash_sdm_gen2.md
MASH_SDM_GEN2 -- requirements
Module: mash_sdm_gen2

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: `clk` rising-edge, `rst` sampled on `clk`.
REQ-002 The module SHALL have these parameters:
  - `W`, default 10, accumulator and input width, 4..24.
  - `LFSR_SEED`, default 15'h0001, nonzero dither LFSR reset value.
REQ-003 The module SHALL have these ports (name, direction, width, meaning):
  - `clk`, in, 1, clock.
  - `rst`, in, 1, synchronous active-high reset.
  - `en`, in, 1, sample strobe; one modulator step per cycle with `en`=1.
  - `din`, in, W, unsigned fractional input, value din/2^W.
  - `order`, in, 2, MASH order select: 0=idle, 1, 2, 3.
  - `dither_en`, in, 1, add LFSR bit into stage-1 LSB.
  - `sdm_out`, out, 4, signed two's-complement modulator output.
  - `out_vld`, out, 1, `sdm_out` updated this cycle.
  - `carry1`, out, 1, registered stage-1 carry of the last step.

Function
REQ-004 The module SHALL hold three W-bit accumulators acc1..acc3, each modulo 2^W.
REQ-005 On an enabled step, the accumulators SHALL update as follows:
  - s1 = acc1 + din + d, with d = dither_en ? lfsr[0] : 0, in W+1 bits; c1 = s1[W]; acc1 <= s1[W-1:0].
  - s2 = acc2 + s1[W-1:0]; c2 = s2[W]; acc2 <= s2[W-1:0].
  - s3 = acc3 + s2[W-1:0]; c3 = s3[W]; acc3 <= s3[W-1:0].
  - The chain is combinational within one step.
REQ-006 Delay registers SHALL hold c2d1 = c2 from the previous step, and c3d1, c3d2 = c3 from one and two steps back; they update only on enabled steps.
REQ-007 The noise-cancellation output y SHALL depend on the order:
  - Order 1: y = c1, range 0..1.
  - Order 2: y = c1 + c2 - c2d1, range -1..2.
  - Order 3: y = c1 + (c2 - c2d1) + (c3 - 2*c3d1 + c3d2), range -3..4.
REQ-008 All arithmetic SHALL be signed and at least 4 bits wide; y SHALL never saturate or wrap within the stated ranges.
REQ-009 On each enabled step, `sdm_out` <= y, `carry1` <= c1 and `out_vld` <= 1 at the same edge; latency is 1 cycle from the `en` sample to `out_vld`.
REQ-010 With `en`=0, accumulators, delay registers, LFSR, `sdm_out` and `carry1` SHALL hold, and `out_vld` <= 0.
REQ-011 Stages unused by the selected order SHALL be held at zero: order 1 clears acc2, acc3, c2d1, c3d1, c3d2; order 2 clears acc3, c3d1, c3d2.
REQ-012 The dither LFSR SHALL be 15 bits, Fibonacci, polynomial x^15+x^14+1, and advance once per enabled step whether or not `dither_en` is set.
REQ-013 `order` SHALL be registered internally (ord_q). When `order` differs from ord_q at an edge, the module SHALL:
  - load ord_q;
  - clear acc1..acc3 and all delay registers;
  - set `sdm_out` <= 0 and `out_vld` <= 0, ignoring `en` that cycle.
  - The next enabled step then starts from the cleared state.
REQ-014 With ord_q=0 (idle), the module SHALL keep accumulators cleared, `sdm_out`=0 and `out_vld`=0 regardless of `en`; the LFSR SHALL hold.
REQ-015 `din`=0 with `dither_en`=0 SHALL give all-zero outputs for every order.
REQ-016 Priority at each edge SHALL be: `rst` > order change > `en`.

Reset
REQ-017 While `rst`=1 at an edge, the module SHALL set:
  - acc1..acc3, c2d1, c3d1, c3d2 <= 0;
  - lfsr <= LFSR_SEED;
  - ord_q <= `order`;
  - `sdm_out` <= 0, `out_vld` <= 0, `carry1` <= 0.
REQ-018 Reset asserted mid-operation SHALL take effect at the same edge and discard any step sampled that cycle; the first `out_vld` SHALL appear no earlier than 2 edges after `rst` deasserts with `en`=1.

Verification
REQ-019 Order 1 halfway: W=10, order=1, din=512, dither off, `en`=1 continuously after reset -> `sdm_out` sequence 0,1,0,1,... with `out_vld`=1 each cycle.
REQ-020 Order 1 near full scale: W=10, order=1, din=1023, dither off, 1024 enabled steps -> exactly 1023 outputs of 1 and one 0; the 0 is the first output.
REQ-021 Order 3 mean: W=10, order=3, din=300, dither off, 1024 enabled steps from reset -> every output in -3..4; sum of outputs in 299..302.
REQ-022 Gapped enable: random `en` gaps with order 2 -> the output sequence restricted to `out_vld` cycles is identical to the gap-free run; held values do not change during gaps.
REQ-023 Order change: switch `order` 3->2 mid-stream -> next cycle `sdm_out`=0 and `out_vld`=0 with all state cleared; the subsequent sequence matches a fresh order-2 run from reset.
REQ-024 Reset and dither: assert `rst` for one cycle during order-3 operation with `dither_en`=1 -> all outputs 0 next edge and lfsr=LFSR_SEED; with din=0, the output is non-zero only when dither bits accumulate to a carry.
